ptw_walker: RTL and testbench
=============================

# ptw_walker

Two-level page table walker that services the TLB's miss channel. On each request it reads the level-1 and, if needed, level-2 page table entries over a single-outstanding memory read port. It then returns one leaf PTE, or 32'h0 on any fault, which the TLB treats as a page fault. The block sits between the TLB and the memory/cache arbiter.

## Interface
Parameters:
- `PTE_BYTES`, 4: PTE size in bytes. Table index is scaled by this value (shift by 2).

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `satp_ppn_i` input 20: root table PPN; sampled at request accept.
- `ptw_req_valid_i` input 1: TLB miss request valid.
- `ptw_req_ready_o` output 1: walker idle, can accept a request.
- `ptw_vaddr_i` input 32: virtual address to translate.
- `ptw_resp_valid_o` output 1: result valid.
- `ptw_resp_ready_i` input 1: TLB accepts the result.
- `ptw_pte_o` output 32: result PTE; 32'h0 means fault.
- `mem_req_valid_o` output 1: memory read request valid.
- `mem_req_ready_i` input 1: memory accepts the request.
- `mem_addr_o` output 32: PTE byte address.
- `mem_resp_valid_i` input 1: read data valid; single cycle, no backpressure.
- `mem_resp_data_i` input 32: PTE read from memory.
- `mem_resp_err_i` input 1: bus error qualifying `mem_resp_valid_i`.
- `fault_cnt_o` output 8: count of faults returned; saturates at 255.

## Operation
- PTE format:
  - [31:12] PPN.
  - [11:3] ignored on input, zero on output.
  - [2] V.
  - [1] W.
  - [0] R.
  - Leaf iff V & (R|W).
  - Pointer iff V & !R & !W.
- VA split:
  - vpn1 = va[31:22].
  - vpn0 = va[21:12].
- States: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - `ptw_req_ready_o`=1.
  - On valid&ready, latch va and satp, go to L1_REQ.
  - `mem_addr_o`={satp_ppn, vpn1, 2'b00}.
- L1_REQ / L2_REQ:
  - `mem_req_valid_o`=1, address held stable.
  - On `mem_req_ready_i`, deassert and go to *_WAIT.
- L1_WAIT, on `mem_resp_valid_i`:
  - err or !V → fault.
  - Pointer → L2_REQ with address {pte[31:12], vpn0, 2'b00}.
  - Leaf → superpage handling (see Configuration).
- L2_WAIT, on `mem_resp_valid_i`:
  - err, !V, or pointer → fault.
  - Leaf → result {pte[31:12], 9'b0, 1'b1, pte[1:0]}.
- RESP:
  - `ptw_resp_valid_o`=1, `ptw_pte_o` held stable.
  - On `ptw_resp_ready_i`, go to IDLE.
- Fault path: enter RESP with `ptw_pte_o`=32'h0 and increment `fault_cnt_o` (saturating).
- `mem_resp_valid_i` outside the *_WAIT states is ignored and dropped.

## Timing
- Reset values (asynchronous assert):
  - state = IDLE.
  - `ptw_req_ready_o`=1.
  - `ptw_resp_valid_o`=0, `ptw_pte_o`=0.
  - `mem_req_valid_o`=0, `mem_addr_o`=0.
  - `fault_cnt_o`=0.
  - Latched va/satp = 0.
- All outputs are registered. `ptw_req_ready_o` drops the cycle after the accept handshake.
- Minimum latency, accept-handshake edge to `ptw_resp_valid_o` high, with memory ready on first cycle and response one cycle later:
  - 5 cycles for a two-level walk.
  - 3 cycles for an L1 leaf or L1 fault.
- One walk in flight; a new request is not accepted until RESP completes.
- Reset mid-walk aborts the walk with no response. A late memory response after reset is ignored.
- `mem_resp_valid_i` arriving in the same cycle as `mem_req_ready_i` is ignored; the response must come at least one cycle later.
- Counter at 255 stays at 255.

## Configuration
- `PTW_SUPERPAGE_EN` defined:
  - An L1 leaf is a 4 MiB superpage.
  - If pte[21:12]≠0 → fault (misaligned).
  - Otherwise result = {pte[31:22], va[21:12], 9'b0, 1'b1, pte[1:0]}.
- Not defined: any L1 leaf → fault.

## Test plan
- Two-level walk:
  - Stimulus: va=0x00403ABC, satp=0x00080.
  - Required: L1 read at 0x00080004 returns 0x00090004; L2 read at 0x0009000C returns 0x12345007.
  - Required: `ptw_pte_o`=0x12345007, 5 cycles with zero-wait memory.
- Superpage (macro on):
  - Stimulus: L1 read returns 0x40000005, same va.
  - Required: `ptw_pte_o`=0x40003005, no L2 read issued.
  - Same PTE with macro off: 0x00000000 and `fault_cnt_o`=1.
- Faults:
  - L1 read returns 0x00000000 → pte 0, one memory read only.
  - L2 read returns 0x00090004 (pointer) → pte 0.
  - `mem_resp_err_i`=1 → pte 0.
  - Misaligned superpage 0x40001005 → pte 0.
- Backpressure:
  - Stimulus: `mem_req_ready_i` low 3 cycles, `ptw_resp_ready_i` low 4 cycles.
  - Required: address and PTE held stable throughout; `ptw_req_ready_o` stays 0 until RESP handshake.
- Reset:
  - Stimulus: `rst`=0 asserted during L2_WAIT, then a stale `mem_resp_valid_i` delivered.
  - Required: immediate IDLE, all outputs at reset values, no `ptw_resp_valid_o`.
- Saturation:
  - Stimulus: 260 faulting walks.
  - Required: `fault_cnt_o`=255.

Source files
------------

// File: rtl/ptw_walker.sv
// ptw_walker: two-level page table walker serving the TLB miss channel.
//
// A request latches the virtual address and the root table PPN. The walker
// then reads the level-1 PTE and, for a pointer PTE, the level-2 PTE. Reads
// go over a memory port that allows one outstanding read. The walker returns
// one leaf PTE, or 32'h0 on any fault. Only one walk is in flight at a time.
//
// Optional feature macro: PTW_SUPERPAGE_EN
//   defined   : a level-1 leaf is a 4 MiB superpage. It must have PPN[9:0] == 0,
//               otherwise it faults as misaligned.
//   undefined : any level-1 leaf faults.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   satp_ppn_i [19:0]        root table PPN, sampled when a request is accepted
//   ptw_req_valid_i/ready_o  TLB miss request handshake
//   ptw_vaddr_i [31:0]       virtual address to translate
//   ptw_resp_valid_o/ready_i result handshake
//   ptw_pte_o [31:0]         result PTE; zero means page fault
//   mem_req_valid_o/ready_i  memory read request handshake
//   mem_addr_o [31:0]        PTE byte address
//   mem_resp_valid_i         read data valid, single cycle, no backpressure
//   mem_resp_data_i [31:0]   PTE read from memory
//   mem_resp_err_i           bus error qualifying mem_resp_valid_i
//   fault_cnt_o [7:0]        saturating count of faults returned
//
// All outputs are registered.

module ptw_walker #(
  parameter int PTE_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] satp_ppn_i,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [31:0] ptw_pte_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  input  logic [31:0] mem_resp_data_i,
  input  logic        mem_resp_err_i,
  output logic [7:0]  fault_cnt_o
);

  localparam int IDX_SHIFT = $clog2(PTE_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L2_REQ  = 3'd3,
    L2_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state, state_n;
  // Only the VPN part of the virtual address matters: va[19:10]=vpn1, va[9:0]=vpn0.
  logic [19:0] va, va_n;
  logic [19:0] satp, satp_n;

  logic        req_ready_n;
  logic        resp_valid_n;
  logic        mem_req_valid_n;
  logic [31:0] mem_addr_n;
  logic [31:0] pte_n;
  logic [7:0]  fault_cnt_n;
  logic        fault;

  logic        pte_v, pte_w, pte_r, pte_ptr;

  // Page offset bits and the ignored PTE field never affect the walk.
  logic unused_bits;
  assign unused_bits = ^{ptw_vaddr_i[11:0], mem_resp_data_i[11:3]};

  assign pte_v   = mem_resp_data_i[2];
  assign pte_w   = mem_resp_data_i[1];
  assign pte_r   = mem_resp_data_i[0];
  assign pte_ptr = pte_v & ~pte_r & ~pte_w;

  function automatic logic [31:0] pte_addr(input logic [19:0] ppn, input logic [9:0] idx);
    pte_addr = {ppn, 12'b0} + (32'(idx) << IDX_SHIFT);
  endfunction

  always_comb begin
    state_n     = state;
    va_n        = va;
    satp_n      = satp;
    mem_addr_n  = mem_addr_o;
    pte_n       = ptw_pte_o;
    fault_cnt_n = fault_cnt_o;
    fault       = 1'b0;

    case (state)
      IDLE: begin
        if (ptw_req_valid_i) begin
          va_n       = ptw_vaddr_i[31:12];
          satp_n     = satp_ppn_i;
          mem_addr_n = pte_addr(satp_ppn_i, ptw_vaddr_i[31:22]);
          state_n    = L1_REQ;
        end
      end
      L1_REQ: begin
        // The address is rebuilt from the latched values, so it stays constant while stalled.
        mem_addr_n = pte_addr(satp, va[19:10]);
        if (mem_req_ready_i) state_n = L1_WAIT;
      end
      L1_WAIT: begin
        if (mem_resp_valid_i) begin
          if (mem_resp_err_i || !pte_v) begin
            fault = 1'b1;
          end else if (pte_ptr) begin
            mem_addr_n = pte_addr(mem_resp_data_i[31:12], va[9:0]);
            state_n    = L2_REQ;
          end else begin
`ifdef PTW_SUPERPAGE_EN
            // For a superpage, vpn0 passes through into the low half of the PPN.
            if (mem_resp_data_i[21:12] != 10'd0) begin
              fault = 1'b1;
            end else begin
              pte_n   = {mem_resp_data_i[31:22], va[9:0], 9'b0, 1'b1, pte_w, pte_r};
              state_n = RESP;
            end
`else
            fault = 1'b1;
`endif
          end
        end
      end
      L2_REQ: begin
        if (mem_req_ready_i) state_n = L2_WAIT;
      end
      L2_WAIT: begin
        if (mem_resp_valid_i) begin
          if (mem_resp_err_i || !pte_v || pte_ptr) begin
            fault = 1'b1;
          end else begin
            pte_n   = {mem_resp_data_i[31:12], 9'b0, 1'b1, pte_w, pte_r};
            state_n = RESP;
          end
        end
      end
      RESP: begin
        if (ptw_resp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (fault) begin
      pte_n   = 32'h0;
      state_n = RESP;
      if (fault_cnt_o != 8'hFF) fault_cnt_n = fault_cnt_o + 8'd1;
    end

    // Handshake outputs are registered copies of the next-state decode.
    req_ready_n     = (state_n == IDLE);
    resp_valid_n    = (state_n == RESP);
    mem_req_valid_n = (state_n == L1_REQ) || (state_n == L2_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      va               <= '0;
      satp             <= '0;
      ptw_req_ready_o  <= 1'b1;
      ptw_resp_valid_o <= 1'b0;
      ptw_pte_o        <= '0;
      mem_req_valid_o  <= 1'b0;
      mem_addr_o       <= '0;
      fault_cnt_o      <= '0;
    end else begin
      state            <= state_n;
      va               <= va_n;
      satp             <= satp_n;
      ptw_req_ready_o  <= req_ready_n;
      ptw_resp_valid_o <= resp_valid_n;
      ptw_pte_o        <= pte_n;
      mem_req_valid_o  <= mem_req_valid_n;
      mem_addr_o       <= mem_addr_n;
      fault_cnt_o      <= fault_cnt_n;
    end
  end

endmodule

// File: tb/tb_ptw_walker.sv
// Scoreboard bench for ptw_walker. Stimulus pushes the expected PTE and the
// expected memory read addresses. Separate monitors pop and compare them at
// each response or memory handshake.

module tb_ptw_walker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [19:0] satp = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] vaddr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] pte;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_err = 1'b0;
  logic [7:0]  fault_cnt;

  always #5 clk = ~clk;

  ptw_walker #(.PTE_BYTES(4)) dut (
    .clk(clk),
    .rst(rst_n),
    .satp_ppn_i(satp),
    .ptw_req_valid_i(req_valid),
    .ptw_req_ready_o(req_ready),
    .ptw_vaddr_i(vaddr),
    .ptw_resp_valid_o(resp_valid),
    .ptw_resp_ready_i(resp_ready),
    .ptw_pte_o(pte),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr),
    .mem_resp_valid_i(mem_resp_valid),
    .mem_resp_data_i(mem_resp_data),
    .mem_resp_err_i(mem_resp_err),
    .fault_cnt_o(fault_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_faults = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

`ifdef PTW_SUPERPAGE_EN
  localparam logic [31:0] SUPER_EXP = 32'h40003005;
`else
  localparam logic [31:0] SUPER_EXP = 32'h00000000;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got no event / unexpected event, required the opposite", name);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) fail_event("unexpected_resp");
      else check("resp_pte", pte, exp_q.pop_front());
    end
  end

  // Memory request monitor
  always @(negedge clk) begin
    if (rst_n && mem_req_valid && mem_req_ready) begin
      if (addr_q.size() == 0) fail_event("unexpected_mem_read");
      else check("mem_addr", mem_addr, addr_q.pop_front());
    end
  end

  // Serve one memory read. Called #1 after a rising edge.
  task automatic mem_read(input int mwait, input logic [31:0] data, input logic err, input bit give_resp);
    int t;
    logic [31:0] a0;
    t = 0;
    while (!mem_req_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!mem_req_valid) begin
      fail_event("mem_req_timeout");
      return;
    end
    a0 = mem_addr;
    for (int i = 0; i < mwait; i++) begin
      @(posedge clk); #1;
      check("mem_req_held", {31'b0, mem_req_valid}, 32'd1);
      check("mem_addr_stable", mem_addr, a0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("mem_req_dropped", {31'b0, mem_req_valid}, 32'd0);
    if (give_resp) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      mem_resp_err   = err;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      mem_resp_err   = 1'b0;
      mem_resp_data  = 32'hDEADBEEF;
    end
  endtask

  // One complete walk. lat = 0 skips the latency check.
  task automatic walk(input logic [31:0] va, input logic [19:0] sp, input int nreads,
                      input logic [31:0] d1, input logic e1, input logic [31:0] d2, input logic e2,
                      input logic [31:0] exp, input int lat, input int mwait, input int rwait);
    int acc, t;
    logic [31:0] p0;
    exp_q.push_back(exp);
    addr_q.push_back({sp, va[31:22], 2'b00});
    if (nreads == 2) addr_q.push_back({d1[31:12], va[21:12], 2'b00});
    if (exp == 32'h0 && exp_faults < 255) exp_faults++;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    vaddr      = va;
    satp       = sp;
    resp_ready = (rwait == 0);
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vaddr     = ~va;
    satp      = ~sp;
    check("req_ready_drop", {31'b0, req_ready}, 32'd0);
    mem_read(mwait, d1, e1, 1'b1);
    if (nreads == 2) mem_read(mwait, d2, e2, 1'b1);
    t = 0;
    while (!resp_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!resp_valid) begin
      fail_event("resp_timeout");
      return;
    end
    if (lat > 0) check("latency", cyc - acc, lat);
    p0 = pte;
    for (int i = 0; i < rwait; i++) begin
      @(posedge clk); #1;
      check("resp_valid_held", {31'b0, resp_valid}, 32'd1);
      check("pte_stable", pte, p0);
      check("req_ready_busy", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("req_ready_back", {31'b0, req_ready}, 32'd1);
    check("fault_cnt", {24'b0, fault_cnt}, exp_faults);
    check("reads_outstanding", addr_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_pte", pte, 32'h0);
    check("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_fault_cnt", {24'b0, fault_cnt}, 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    //   va            satp      n  L1 data       e  L2 data       e  expected     lat mw rw
    walk(32'h00403ABC, 20'h00080, 2, 32'h00090004, 0, 32'h12345007, 0, 32'h12345007, 5, 0, 0);
    walk(32'h00403ABC, 20'h00080, 1, 32'h40000005, 0, 32'h0,        0, SUPER_EXP,    3, 0, 0);
    walk(32'h00403ABC, 20'h00080, 1, 32'h00000000, 0, 32'h0,        0, 32'h0,        3, 0, 0);
    walk(32'h00403ABC, 20'h00080, 2, 32'h00090004, 0, 32'h00090004, 0, 32'h0,        5, 0, 0);
    walk(32'h00403ABC, 20'h00080, 1, 32'h00090004, 1, 32'h0,        0, 32'h0,        3, 0, 0);
    walk(32'h00403ABC, 20'h00080, 2, 32'h00090004, 0, 32'h12345007, 1, 32'h0,        5, 0, 0);
    walk(32'h00403ABC, 20'h00080, 2, 32'h00090004, 0, 32'h12345003, 0, 32'h0,        5, 0, 0);
    walk(32'h00403ABC, 20'h00080, 1, 32'h40001005, 0, 32'h0,        0, 32'h0,        3, 0, 0);
    walk(32'h00000000, 20'h00001, 2, 32'h00002004, 0, 32'hABCDE005, 0, 32'hABCDE005, 5, 0, 0);
    walk(32'hFFC01000, 20'hABCDE, 2, 32'h55555FF4, 0, 32'hCAFEBFFE, 0, 32'hCAFEB006, 0, 3, 4);

    // Reset while waiting for the level-2 response, then a stale response.
    req_valid  = 1'b1;
    vaddr      = 32'h00403ABC;
    satp       = 20'h00080;
    resp_ready = 1'b1;
    addr_q.push_back(32'h00080004);
    addr_q.push_back(32'h0009000C);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_read(0, 32'h00090004, 1'b0, 1'b1);
    mem_read(0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_faults = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h12345007;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stale_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("stale_req_ready", {31'b0, req_ready}, 32'd1);
      check("stale_mem_req", {31'b0, mem_req_valid}, 32'd0);
    end
    resp_ready = 1'b0;

    // Fault counter saturation.
    for (int i = 0; i < 260; i++)
      walk(32'h00403ABC, 20'h00080, 1, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    check("fault_cnt_saturated", {24'b0, fault_cnt}, 32'd255);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
